// File: rtl/spart_rx_fifo.sv
// UART receive path: 16x oversampled, 3-sample majority, optional parity,
// feeding a first-word-fall-through FIFO that keeps per-word error flags.
module spart_rx_fifo #(
  parameter int DATA_BITS = 8,
  parameter int DEPTH     = 8,
  parameter int CW        = $clog2(DEPTH+1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  input  logic [15:0]          divisor,
  input  logic [1:0]           parity_mode,
  input  logic                 rd_en,
  input  logic                 clr_err,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 rd_parity_err,
  output logic                 rd_frame_err,
  output logic                 empty,
  output logic                 full,
  output logic [CW-1:0]        count,
  output logic                 overrun,
  output logic                 busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(DATA_BITS);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state;
  logic                 rx_meta, rxs;
  logic [15:0]          tick_cnt, div_q, div_in;
  logic [3:0]           tick_idx;
  logic [BW-1:0]        bit_idx;
  logic                 s7, s8, maj, tick, push, pop, wr_en;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_en, par_odd, par_err;

  logic [DATA_BITS+1:0] mem [DEPTH];
  logic [AW:0]          wr_ptr, rd_ptr;

  assign div_in = (divisor < 16'd2) ? 16'd1 : divisor;
  assign maj    = (s7 & s8) | (s7 & rxs) | (s8 & rxs);
  assign tick   = (state != IDLE) && (tick_cnt == '0);
  assign push   = (state == STOP) && tick && (tick_idx == 4'd9);
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tick_cnt <= '0;
      div_q    <= 16'd1;
      tick_idx <= '0;
      bit_idx  <= '0;
      s7       <= 1'b1;
      s8       <= 1'b1;
      shreg    <= '0;
      par_en   <= 1'b0;
      par_odd  <= 1'b0;
      par_err  <= 1'b0;
    end else if (state == IDLE) begin
      // Start edge: latch frame config and phase-align the tick counter.
      if (!rxs) begin
        state    <= START;
        tick_cnt <= div_in - 16'd1;
        div_q    <= div_in;
        tick_idx <= '0;
        par_en   <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
        par_odd  <= (parity_mode == 2'b10);
        par_err  <= 1'b0;
      end
    end else if (!tick) begin
      tick_cnt <= tick_cnt - 16'd1;
    end else begin
      tick_cnt <= div_q - 16'd1;
      tick_idx <= tick_idx + 4'd1;
      if (tick_idx == 4'd7) s7 <= rxs;
      if (tick_idx == 4'd8) s8 <= rxs;
      case (state)
        START: begin
          if (tick_idx == 4'd9 && maj) state <= IDLE;
          else if (tick_idx == 4'd15) begin
            state   <= DATA;
            bit_idx <= '0;
          end
        end
        DATA: begin
          if (tick_idx == 4'd9) shreg[bit_idx] <= maj;
          if (tick_idx == 4'd15) begin
            if (bit_idx == BW'(DATA_BITS-1)) state <= par_en ? PARITY : STOP;
            else bit_idx <= bit_idx + 1'b1;
          end
        end
        PARITY: begin
          if (tick_idx == 4'd9)  par_err <= (^shreg) ^ maj ^ par_odd;
          if (tick_idx == 4'd15) state <= STOP;
        end
        STOP:    if (tick_idx == 4'd9) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Extra wrap bit on each pointer separates full from empty.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = CW'(wr_ptr - rd_ptr);
  assign pop   = rd_en & ~empty;
  assign wr_en = push & (~full | pop);
  assign {rd_data, rd_parity_err, rd_frame_err} = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      overrun <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr[AW-1:0]] <= {shreg, par_err, ~maj};
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push & full & ~pop) overrun <= 1'b1;
      else if (clr_err)       overrun <= 1'b0;
    end
  end
endmodule

// File: tb/tb_spart_rx_fifo.sv
// Directed bench for spart_rx_fifo: a queue model predicts FIFO contents and
// push timing from frame arithmetic; a negedge process compares every cycle.
module tb_spart_rx_fifo;
  localparam int DEPTH = 8;

  logic        clk = 1'b0, rst = 1'b1, rxd = 1'b1, rd_en = 1'b0, clr_err = 1'b0;
  logic [15:0] divisor = 16'd4;
  logic [1:0]  parity_mode = 2'b00;
  logic [7:0]  rd_data;
  logic        rd_parity_err, rd_frame_err, empty, full, overrun, busy;
  logic [3:0]  count;

  spart_rx_fifo #(.DATA_BITS(8), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .divisor(divisor), .parity_mode(parity_mode),
    .rd_en(rd_en), .clr_err(clr_err), .rd_data(rd_data), .rd_parity_err(rd_parity_err),
    .rd_frame_err(rd_frame_err), .empty(empty), .full(full), .count(count),
    .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0, cyc = 0, dv = 4;

  typedef struct {int edge_n; logic [7:0] d; logic pe; logic fe;} pend_t;
  typedef struct {logic [7:0] d; logic pe; logic fe;} ent_t;
  pend_t pend[$];
  ent_t  mq[$];
  logic  m_ov = 1'b0;
  ent_t  m_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: a frame whose start bit is driven after edge N is pushed at edge
  // N + 2 (synchroniser) + 1 (start detect) + dv*(tick index of stop tick 9 + 1).
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      mq.delete();
      pend.delete();
      m_ov = 1'b0;
    end else begin
      if (rd_en && mq.size() > 0) void'(mq.pop_front());
      if (pend.size() > 0 && pend[0].edge_n == cyc) begin
        m_e = '{pend[0].d, pend[0].pe, pend[0].fe};
        void'(pend.pop_front());
        if (mq.size() < DEPTH) mq.push_back(m_e);
        else m_ov = 1'b1;
      end else if (clr_err) m_ov = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst)
      chk("reset_state", {empty, full, count, overrun, busy, rd_data, rd_parity_err, rd_frame_err},
          {1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 8'd0, 2'b00});
    else begin
      chk("fifo_status", {empty, full, count, overrun},
          {mq.size() == 0, mq.size() == DEPTH, 4'(mq.size()), m_ov});
      if (mq.size() > 0)
        chk("head", {rd_data, rd_parity_err, rd_frame_err}, {mq[0].d, mq[0].pe, mq[0].fe});
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pop1();
    rd_en = 1'b1;
    cycles(1);
    rd_en = 1'b0;
  endtask

  // glitch_bit >= 0 inverts rxd for one clock mid-way through that data bit.
  task automatic send_frame(input logic [7:0] d, input logic [1:0] pm, input logic pbit,
                            input logic stopb, input int glitch_bit);
    bit par;
    int nb;
    logic x;
    par = (pm == 2'b01) || (pm == 2'b10);
    nb  = 9 + (par ? 1 : 0);
    x   = (^d) ^ pbit;
    parity_mode = pm;
    pend.push_back('{cyc + 3 + dv*(16*nb + 10), d,
                     par ? ((pm == 2'b01) ? (x != 1'b0) : (x != 1'b1)) : 1'b0, ~stopb});
    rxd = 1'b0;
    cycles(16*dv);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      if (i == glitch_bit) begin
        cycles(8*dv);
        rxd = ~d[i];
        cycles(1);
        rxd = d[i];
        cycles(8*dv - 1);
      end else cycles(16*dv);
    end
    if (par) begin
      rxd = pbit;
      cycles(16*dv);
    end
    rxd = stopb;
    cycles(16*dv);
    rxd = 1'b1;
  endtask

  logic [7:0] bb [3];
  logic [7:0] v5a;
  int pe_edge;

  initial begin
    bb[0] = 8'hA5; bb[1] = 8'hE7; bb[2] = 8'h24;
    cycles(3);
    chk("reset_literal", {empty, count, busy, rd_data}, {1'b1, 4'd0, 1'b0, 8'h00});
    rst = 1'b0;
    cycles(5);

    // Basic receive, divisor 4, 8N1
    send_frame(8'hA5, 2'b00, 1'b0, 1'b1, -1);
    chk("basic_rx", {empty, count, rd_data, rd_parity_err, rd_frame_err}, {1'b0, 4'd1, 8'hA5, 2'b00});
    pop1();
    chk("basic_pop", empty, 1'b1);

    // Back-to-back frames
    for (int i = 0; i < 3; i++) send_frame(bb[i], 2'b00, 1'b0, 1'b1, -1);
    for (int i = 0; i < 3; i++) begin
      chk("b2b_head", {count, rd_data, rd_parity_err, rd_frame_err}, {4'(3 - i), bb[i], 2'b00});
      pop1();
    end
    chk("b2b_drained", count, 4'd0);

    // Parity: 0xE7 has six ones
    send_frame(8'hE7, 2'b01, 1'b0, 1'b1, -1);
    chk("even_pbit0", rd_parity_err, 1'b0);
    pop1();
    send_frame(8'hE7, 2'b01, 1'b1, 1'b1, -1);
    chk("even_pbit1", rd_parity_err, 1'b1);
    pop1();
    send_frame(8'hE7, 2'b10, 1'b0, 1'b1, -1);
    chk("odd_pbit0", rd_parity_err, 1'b1);
    pop1();
    parity_mode = 2'b00;

    // Framing error; the held-low stop bit then looks like a false start
    send_frame(8'hA5, 2'b00, 1'b0, 1'b0, -1);
    chk("frame_err", {rd_data, rd_frame_err, rd_parity_err}, {8'hA5, 2'b10});
    pop1();
    cycles(32*dv);
    chk("frame_err_idle", busy, 1'b0);

    // Short low pulse rejected at the start-bit vote
    rxd = 1'b0;
    cycles(20);
    rxd = 1'b1;
    cycles(2);
    chk("glitch_busy", busy, 1'b1);
    cycles(60);
    chk("glitch_reject", {busy, empty}, {1'b0, 1'b1});

    // One-clock glitch inside a data bit
    send_frame(8'h3C, 2'b00, 1'b0, 1'b1, 2);
    send_frame(8'h3C, 2'b00, 1'b0, 1'b1, 5);
    chk("vote_recovers", {count, rd_data}, {4'd2, 8'h3C});
    pop1();
    pop1();

    // Overrun: DEPTH+1 frames, no reads
    for (int i = 0; i <= DEPTH; i++) send_frame(8'h10 + 8'(i), 2'b00, 1'b0, 1'b1, -1);
    chk("ovr_full", {full, overrun, count}, {1'b1, 1'b1, 4'd8});
    clr_err = 1'b1;
    cycles(1);
    clr_err = 1'b0;
    chk("ovr_cleared", {overrun, full}, {1'b0, 1'b1});
    for (int i = 0; i < DEPTH; i++) begin
      chk("ovr_data", rd_data, 8'h10 + 8'(i));
      pop1();
    end
    chk("ovr_drained", empty, 1'b1);

    // Full FIFO with a pop on the push cycle: accepted, no overrun
    for (int i = 0; i < DEPTH; i++) send_frame(8'h20 + 8'(i), 2'b00, 1'b0, 1'b1, -1);
    pe_edge = cyc + 3 + dv*(16*9 + 10);
    fork
      send_frame(8'h99, 2'b00, 1'b0, 1'b1, -1);
      begin
        while (cyc < pe_edge - 1) cycles(1);
        rd_en = 1'b1;
        cycles(1);
        rd_en = 1'b0;
      end
    join
    chk("push_pop_full", {full, overrun, count, rd_data}, {1'b1, 1'b0, 4'd8, 8'h21});
    for (int i = 0; i < DEPTH; i++) pop1();
    chk("push_pop_tail", empty, 1'b1);

    // Reset during data bit 3 with one word already queued
    send_frame(8'h77, 2'b00, 1'b0, 1'b1, -1);
    v5a = 8'h5A;
    rxd = 1'b0;
    cycles(16*dv);
    for (int i = 0; i < 3; i++) begin
      rxd = v5a[i];
      cycles(16*dv);
    end
    rxd = v5a[3];
    cycles(8*dv);
    chk("midframe_busy", {busy, count}, {1'b1, 4'd1});
    rst = 1'b1;
    rxd = 1'b1;
    #1;
    chk("midframe_reset", {empty, full, count, overrun, busy, rd_data, rd_parity_err, rd_frame_err},
        {1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 8'h00, 2'b00});
    cycles(2);
    rst = 1'b0;
    cycles(10);
    send_frame(8'h5A, 2'b00, 1'b0, 1'b1, -1);
    chk("after_reset_rx", {count, rd_data, rd_parity_err, rd_frame_err}, {4'd1, 8'h5A, 2'b00});
    pop1();

    // Divisor 0 behaves as 1: one tick per clock
    divisor = 16'd0;
    dv = 1;
    cycles(4);
    send_frame(8'h81, 2'b00, 1'b0, 1'b1, -1);
    chk("div0_rx", {count, rd_data}, {4'd1, 8'h81});
    pop1();
    cycles(10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
